// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide stage: opcodes, FSM state type,
// default latencies and the divide helper.
package mdu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MULT  = 4'h1;
    localparam logic [3:0] OP_MULTU = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_DIVU  = 4'h4;
    localparam logic [3:0] OP_MFHI  = 4'h5;
    localparam logic [3:0] OP_MFLO  = 4'h6;
    localparam logic [3:0] OP_MTHI  = 4'h7;
    localparam logic [3:0] OP_MTLO  = 4'h8;
    localparam logic [3:0] OP_MADD  = 4'h9;
    localparam logic [3:0] OP_MADDU = 4'hA;
    localparam logic [3:0] OP_MSUB  = 4'hB;
    localparam logic [3:0] OP_MSUBU = 4'hC;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Returns {remainder, quotient}. Signed mode works on magnitudes and fixes
    // signs afterwards, which also yields 0x80000000/-1 = 0x80000000 rem 0.
    function automatic logic [63:0] div_hilo(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        is_signed);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        ua = (is_signed && a[31]) ? -a : a;
        ub = (is_signed && b[31]) ? -b : b;
        if (ub == 32'd0) ub = 32'd1;
        q = ua / ub;
        r = ua % ub;
        if (is_signed && (a[31] ^ b[31])) q = -q;
        if (is_signed && a[31]) r = -r;
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu_stage.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU; otherwise those codes are no-ops.
import mdu_pkg::*;

// state   | meaning
// ST_IDLE | HI/LO stable, accepting Start
// ST_RUN  | counting down; shadow result committed when counter reaches 1
module mdu_stage #(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_hi_sh;
    logic [31:0]   r_lo_sh;
    logic          r_wr;

    logic [63:0]   w_prod_s;
    logic [63:0]   w_prod_u;
    logic [63:0]   w_res;
    logic          w_launch;
    logic          w_is_div;
    logic          w_wr;
    logic          w_accept;

    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};
    assign w_accept = Start && (r_state == ST_IDLE);

    always_comb begin
        w_launch = 1'b0;
        w_is_div = 1'b0;
        w_wr     = 1'b1;
        w_res    = 64'd0;
        case (MDOp)
            OP_MULT:  begin w_launch = 1'b1; w_res = w_prod_s; end
            OP_MULTU: begin w_launch = 1'b1; w_res = w_prod_u; end
            OP_DIV: begin
                w_launch = 1'b1;
                w_is_div = 1'b1;
                w_wr     = (B != 32'd0);
                w_res    = div_hilo(A, B, 1'b1);
            end
            OP_DIVU: begin
                w_launch = 1'b1;
                w_is_div = 1'b1;
                w_wr     = (B != 32'd0);
                w_res    = div_hilo(A, B, 1'b0);
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin w_launch = 1'b1; w_res = {r_hi, r_lo} + w_prod_s; end
            OP_MADDU: begin w_launch = 1'b1; w_res = {r_hi, r_lo} + w_prod_u; end
            OP_MSUB:  begin w_launch = 1'b1; w_res = {r_hi, r_lo} - w_prod_s; end
            OP_MSUBU: begin w_launch = 1'b1; w_res = {r_hi, r_lo} - w_prod_u; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_sh <= 32'd0;
            r_lo_sh <= 32'd0;
            r_wr    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_accept && w_launch) begin
                r_state <= ST_RUN;
                r_cnt   <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_hi_sh <= w_res[63:32];
                r_lo_sh <= w_res[31:0];
                r_wr    <= w_wr;
            end else if (w_accept && MDOp == OP_MTHI) begin
                r_hi <= A;
            end else if (w_accept && MDOp == OP_MTLO) begin
                r_lo <= A;
            end
        end else begin
            // Start is ignored while running; only the countdown advances.
            if (r_cnt == CW'(1)) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                if (r_wr) begin
                    r_hi <= r_hi_sh;
                    r_lo <= r_lo_sh;
                end
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        Out = 32'd0;
        case (MDOp)
            OP_MFHI: Out = r_hi;
            OP_MFLO: Out = r_lo;
            default: ;
        endcase
    end

    assign Busy   = (r_state == ST_RUN);
    assign HI_out = r_hi;
    assign LO_out = r_lo;

endmodule

// File: tb/tb_mdu_stage.sv
// Self-checking bench for mdu_stage: expected HI/LO/busy-length records are queued
// at issue time and popped when the operation completes.
module tb_mdu_stage;
    import mdu_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic [31:0] Out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    mdu_stage dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI_out (HI_out),
        .LO_out (LO_out),
        .Out    (Out)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    // Called at a negedge; returns at the first negedge with Busy low.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; MDOp = OP_NOP; A = 32'd0; B = 32'd0;
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic set_hilo(input logic [31:0] hi, input logic [31:0] lo);
        Start = 1'b1; MDOp = OP_MTHI; A = hi;
        @(negedge Clk);
        MDOp = OP_MTLO; A = lo;
        @(negedge Clk);
        Start = 1'b0; MDOp = OP_NOP; A = 32'd0;
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa;
        int              sbv;
        int              q;
        int              r;
        sa  = a;
        sbv = b;
        case (op)
            OP_MULT:  begin ps = longint'(sa) * longint'(sbv); return ps; end
            OP_MULTU: begin pu = longint'({32'd0, a}) * longint'({32'd0, b}); return pu; end
            OP_DIV:   begin q = sa / sbv; r = sa % sbv; return {r, q}; end
            default:  return {a % b, a / b};
        endcase
    endfunction

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; MDOp = OP_NOP; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge Clk);
        checks++;
        if ({Busy, HI_out, LO_out, Out} !== 97'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b hi=%h lo=%h out=%h, want all zero", Busy, HI_out, LO_out, Out);
        end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_mult();
        int   n;
        exp_t e;
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles) begin
            failures++;
            $display("FAIL mult_busy: got %0d cycles, want %0d", n, e.cycles);
        end
        checks++;
        if ({HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL mult_result: got %h_%h, want %h_%h", HI_out, LO_out, e.hi, e.lo);
        end
    endtask

    task automatic test_div();
        int   n;
        exp_t e;
        sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles) begin
            failures++;
            $display("FAIL div_busy: got %0d cycles, want %0d", n, e.cycles);
        end
        checks++;
        if ({HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL div_result: got %h_%h, want %h_%h", HI_out, LO_out, e.hi, e.lo);
        end
        sb.push_back('{32'h0000_0000, 32'h8000_0000, 10});
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL div_overflow: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_div_zero();
        int   n;
        exp_t e;
        set_hilo(32'hAAAA_0001, 32'h5555_0002);
        sb.push_back('{32'hAAAA_0001, 32'h5555_0002, 10});
        issue(OP_DIVU, 32'd7, 32'd0, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL divu_zero: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
        sb.push_back('{32'hAAAA_0001, 32'h5555_0002, 10});
        issue(OP_DIV, 32'hFFFF_FF00, 32'd0, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL div_zero: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_move();
        int busy_seen = 0;
        Start = 1'b1; MDOp = OP_MTHI; A = 32'h1234_5678;
        @(negedge Clk);
        if (Busy !== 1'b0) busy_seen++;
        Start = 1'b0; MDOp = OP_MFHI; A = 32'd0;
        #1;
        checks++;
        if (Out !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mfhi_out: got %h, want %h", Out, 32'h1234_5678);
        end
        Start = 1'b1; MDOp = OP_MTLO; A = 32'hCAFE_F00D;
        @(negedge Clk);
        if (Busy !== 1'b0) busy_seen++;
        Start = 1'b0; MDOp = OP_MFLO; A = 32'd0;
        #1;
        checks++;
        if (Out !== 32'hCAFE_F00D || HI_out !== 32'h1234_5678) begin
            failures++;
            $display("FAIL mflo_out: got out=%h hi=%h, want out=%h hi=%h", Out, HI_out, 32'hCAFE_F00D, 32'h1234_5678);
        end
        MDOp = OP_MULT;
        #1;
        checks++;
        if (Out !== 32'd0 || busy_seen !== 0) begin
            failures++;
            $display("FAIL out_non_mf: got out=%h busy_seen=%0d, want 0 and 0", Out, busy_seen);
        end
        MDOp = OP_NOP;
        @(negedge Clk);
    endtask

    task automatic test_start_ignored();
        int   n;
        exp_t e;
        sb.push_back('{32'd0, 32'd12, 5});
        Start = 1'b1; MDOp = OP_MULT; A = 32'd3; B = 32'd4;
        @(negedge Clk);
        MDOp = OP_DIV; A = 32'd1; B = 32'd1;
        @(negedge Clk);
        Start = 1'b0; MDOp = OP_NOP; A = 32'd0; B = 32'd0;
        n = 1;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            @(negedge Clk);
        end
        @(negedge Clk);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || Busy !== 1'b0 || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL start_while_busy: got %0d cycles busy=%b %h_%h, want %0d cycles busy=0 %h_%h",
                     n, Busy, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_random();
        int          n;
        exp_t        e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            if (b == 32'd0) b = 32'd5;
            if (a == 32'h8000_0000) a = 32'h7FFF_0000;
            if (i % 2 == 1) b = b >> 20;
            if (b == 32'd0) b = 32'd3;
            m = model(op, a, b);
            sb.push_back('{m[63:32], m[31:0], (op == OP_DIV || op == OP_DIVU) ? 10 : 5});
            issue(op, a, b, n);
            e = sb.pop_front();
            checks++;
            if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
                failures++;
                $display("FAIL random_op%0d: op=%h a=%h b=%h got %0d cycles %h_%h, want %0d cycles %h_%h",
                         i, op, a, b, n, HI_out, LO_out, e.cycles, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_rst_abort();
        set_hilo(32'h1111_1111, 32'h2222_2222);
        Start = 1'b1; MDOp = OP_DIVU; A = 32'd100; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0; MDOp = OP_NOP; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got busy=%b, want 1", Busy);
        end
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            failures++;
            $display("FAIL abort_immediate: got busy=%b hi=%h lo=%h, want 0 0 0", Busy, HI_out, LO_out);
        end
        @(negedge Clk);
        Rst = 1'b0;
        repeat (15) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            failures++;
            $display("FAIL abort_no_write: got busy=%b hi=%h lo=%h, want 0 0 0", Busy, HI_out, LO_out);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        sb.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 5});
        sb.push_back('{32'h0000_0002, 32'hFFFF_FFF2, 10});
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL b2b_multu: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL b2b_div: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_madd();
        int   n;
        exp_t e;
        set_hilo(32'd0, 32'd10);
`ifdef MDU_MADD_EN
        sb.push_back('{32'd0, 32'd16, 5});
`else
        sb.push_back('{32'd0, 32'd10, 0});
`endif
        issue(OP_MADD, 32'd2, 32'd3, n);
        e = sb.pop_front();
        checks++;
        if (n !== e.cycles || {HI_out, LO_out} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL madd: got %0d cycles %h_%h, want %0d cycles %h_%h",
                     n, HI_out, LO_out, e.cycles, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_move();
        test_start_ignored();
        test_random();
        test_rst_abort();
        test_back_to_back();
        test_madd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
